// File: rtl/data_mem_pkg.sv
// Shared types and lane constants for the data-memory initiator.
package data_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

endpackage

// File: rtl/data_lane_align.sv
// Combinational lane handling: extract+extend a loaded lane, or merge a store lane into the old word.
module data_lane_align
  import data_mem_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic              store_path,
  input  size_t             size,
  input  logic [1:0]        offset,
  input  logic              sign_ext,
  input  logic [WIDTH-1:0]  word,
  input  logic [HALF_W-1:0] lane,
  output logic [WIDTH-1:0]  data
);

  logic [4:0]        shift;
  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;
  logic [WIDTH-1:0]  ext;
  logic [WIDTH-1:0]  merged;

  assign shift  = {offset, 3'b000};
  assign byte_v = word[shift +: BYTE_W];
  assign half_v = word[shift +: HALF_W];

  always_comb begin
    ext    = word;
    merged = word;
    case (size)
      SZ_BYTE: begin
        ext = {{(WIDTH-BYTE_W){sign_ext & byte_v[BYTE_W-1]}}, byte_v};
        merged[shift +: BYTE_W] = lane[BYTE_W-1:0];
      end
      SZ_HALF: begin
        ext = {{(WIDTH-HALF_W){sign_ext & half_v[HALF_W-1]}}, half_v};
        merged[shift +: HALF_W] = lane;
      end
      default: ;
    endcase
  end

  assign data = store_path ? merged : ext;

endmodule

// File: rtl/data_mem_master.sv
// Data-memory initiator: load/store requests in, single-port memory out, sub-word stores by read-modify-write.
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_t            state, state_nxt;
  size_t             size_q;
  logic              unsigned_q;
  logic [HALF_W-1:0] lane_q;
  logic              accept;
  logic              bad_req;
  logic [WIDTH-1:0]  load_data;
  logic [WIDTH-1:0]  merge_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign bad_req   = (req_size == SZ_RSVD) || ((req_size == SZ_HALF) && req_addr[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // mem_we is decoded from state so an async reset kills a pending negedge write at once
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_req)                  state_nxt = RESP;
          else if (!req_we)             state_nxt = LOAD;
          else if (req_size == SZ_WORD) state_nxt = STORE;
          else                          state_nxt = RMW_RD;
        end
      end
      LOAD:   state_nxt = RESP;
      STORE: begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      RMW_RD: state_nxt = RMW_WR;
      RMW_WR: begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      lane_q     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            size_q     <= size_t'(req_size);
            unsigned_q <= req_unsigned;
            lane_q     <= req_wdata[HALF_W-1:0];
            rsp_err    <= bad_req;
            rsp_rdata  <= '0;
            if (!bad_req) mem_addr <= req_addr;
            if (!bad_req && req_we && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
          end
        end
        LOAD:   rsp_rdata <= load_data;
        // the merged word is registered here and written during RMW_WR
        RMW_RD: mem_wdata <= merge_data;
        default: ;
      endcase
    end
  end

  data_lane_align #(.WIDTH(WIDTH)) u_load_align (
    .store_path (1'b0),
    .size       (size_q),
    .offset     (mem_addr[1:0]),
    .sign_ext   (~unsigned_q),
    .word       (mem_rdata),
    .lane       ('0),
    .data       (load_data)
  );

  data_lane_align #(.WIDTH(WIDTH)) u_store_align (
    .store_path (1'b1),
    .size       (size_q),
    .offset     (mem_addr[1:0]),
    .sign_ext   (1'b0),
    .word       (mem_rdata),
    .lane       (lane_q),
    .data       (merge_data)
  );

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a negedge-write memory model and a response scoreboard.
module tb_data_mem_master;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [1:0]       req_size = 2'b00;
  logic             req_unsigned = 1'b0;
  logic [WIDTH-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic [WIDTH-1:0] mem [0:63];
  int vectors = 0;
  int miscompares = 0;
  int writes = 0;

  typedef struct {
    logic [WIDTH-1:0] rdata;
    logic             err;
  } exp_t;
  exp_t sb[$];

  data_mem_master #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      writes++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic expect_rsp(input logic [WIDTH-1:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // returns after the accept edge
  task automatic accept();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // edges counted including the accept edge
  task automatic wait_rsp(input string tag, input int exp_edges);
    int n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_edges));
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, e.err});
    end
    rsp_ready = 1'b1;
    tick();
    check({tag, "_done"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                    input logic [WIDTH-1:0] exp_rdata, input logic exp_err,
                    input int exp_edges, input int exp_writes);
    int w0;
    w0 = writes;
    expect_rsp(exp_rdata, exp_err);
    drive(we, sz, uns, a, d);
    accept();
    wait_rsp({tag, "_lat"}, exp_edges);
    take_rsp(tag);
    check({tag, "_writes"}, 64'(writes - w0), 64'(exp_writes));
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    int w0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    #12;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    op("st_word", 1'b1, 2'b10, 1'b0, 64'h8, 64'h1122334455667788, 64'd0, 1'b0, 2, 1);
    check("st_word_mem", mem[2], 64'h1122334455667788);
    op("ld_word", 1'b0, 2'b10, 1'b0, 64'h8, 64'd0, 64'h1122334455667788, 1'b0, 2, 0);

    mem[1] = 64'h00000000_80FF7F01;
    op("ld_b5_s", 1'b0, 2'b00, 1'b0, 64'h5, 64'd0, 64'h000000000000007F, 1'b0, 2, 0);
    op("ld_b6_s", 1'b0, 2'b00, 1'b0, 64'h6, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2, 0);
    op("ld_h6_u", 1'b0, 2'b01, 1'b1, 64'h6, 64'd0, 64'h00000000000080FF, 1'b0, 2, 0);
    op("ld_h6_s", 1'b0, 2'b01, 1'b0, 64'h6, 64'd0, 64'hFFFFFFFFFFFF80FF, 1'b0, 2, 0);
    op("ld_b6_u", 1'b0, 2'b00, 1'b1, 64'h6, 64'd0, 64'h00000000000000FF, 1'b0, 2, 0);

    // byte store by read-modify-write, stepping through each phase
    mem[1] = 64'h0000000012345678;
    w0 = writes;
    expect_rsp(64'd0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 64'h7, 64'h00000000000000AB);
    accept();
    check("rmw_rd_we", {63'd0, mem_we}, 64'd0);
    tick();
    check("rmw_wr_we", {63'd0, mem_we}, 64'd1);
    check("rmw_wr_wdata", mem_wdata, 64'h00000000AB345678);
    tick();
    check("rmw_lat3", {63'd0, rsp_valid}, 64'd1);
    take_rsp("st_b7");
    check("st_b7_writes", 64'(writes - w0), 64'd1);
    check("st_b7_mem", mem[1], 64'h00000000AB345678);
    op("st_h4", 1'b1, 2'b01, 1'b0, 64'h4, 64'h000000000000BEEF, 64'd0, 1'b0, 3, 1);
    check("st_h4_mem", mem[1], 64'h00000000AB34BEEF);

    op("err_h3", 1'b0, 2'b01, 1'b0, 64'h3, 64'd0, 64'd0, 1'b1, 1, 0);
    op("err_rsvd", 1'b1, 2'b11, 1'b0, 64'h8, 64'hDEAD, 64'd0, 1'b1, 1, 0);
    check("err_mem", mem[2], 64'h1122334455667788);

    // response backpressure with a second request waiting
    rsp_ready = 1'b0;
    expect_rsp(64'h1122334455667788, 1'b0);
    drive(1'b0, 2'b10, 1'b0, 64'h8, 64'd0);
    accept();
    wait_rsp("bp_lat", 2);
    held = rsp_rdata;
    expect_rsp(64'h0000000000000088, 1'b0);
    drive(1'b0, 2'b00, 1'b1, 64'h8, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    take_rsp("bp_first");
    accept();
    wait_rsp("bp_second_lat", 2);
    take_rsp("bp_second");

    // reset while the RMW write is pending
    w0 = writes;
    drive(1'b1, 2'b00, 1'b0, 64'h9, 64'h00000000000000CC);
    accept();
    tick();
    check("rst_rmw_we_pre", {63'd0, mem_we}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_rmw_we_drop", {63'd0, mem_we}, 64'd0);
    @(negedge clk);
    #1;
    check("rst_rmw_mem", mem[2], 64'h1122334455667788);
    check("rst_rmw_writes", 64'(writes - w0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_rel_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rel_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    op("ld_after_rst", 1'b0, 2'b10, 1'b0, 64'h8, 64'd0, 64'h1122334455667788, 1'b0, 2, 0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
